// File: rtl/fetch_sequencer_if.sv
// Bus bundle between fetch_sequencer, the opcode buffer and the decode stage.
// master: the sequencer side. slave: the buffer/decode environment side.
interface fetch_sequencer_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned WORD_WIDTH    = 32
) ();
    // Opcode buffer request/response
    logic [ADDRESS_WIDTH-1:0] ip;
    logic                     startLoading;
    logic                     busy;
    logic [WORD_WIDTH-1:0]    opcode;
    // Control-flow redirect
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirectPc;
    // Decode handshake
    logic [WORD_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] instrPc;
    logic                     instrValid;
    logic                     instrReady;

    modport master (
        output ip, startLoading, instr, instrPc, instrValid,
        input  busy, opcode, redirect, redirectPc, instrReady
    );

    modport slave (
        input  ip, startLoading, instr, instrPc, instrValid,
        output busy, opcode, redirect, redirectPc, instrReady
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one opcode-buffer request at a time,
// captures each returned opcode into a prefetch FIFO drained by decode.
// A redirect flushes the FIFO and restarts fetch; an in-flight buffer
// transaction cannot be aborted, so its result is dropped via a discard flag.
module fetch_sequencer #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              WORD_WIDTH    = 32,
    parameter int unsigned              DEPTH         = 4,  // power of two, >= 2
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    localparam int unsigned PtrWidth   = $clog2(DEPTH);
    localparam int unsigned CountWidth = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitBusy, StWaitDone} stateE;

    stateE                    stateQ;
    logic [ADDRESS_WIDTH-1:0] pcQ;
    logic [ADDRESS_WIDTH-1:0] ipQ;
    logic                     startLoadingQ;
    logic                     discardQ;

    logic [WORD_WIDTH-1:0]    memWord [DEPTH];
    logic [ADDRESS_WIDTH-1:0] memPc   [DEPTH];
    logic [PtrWidth-1:0]      wrPtrQ;
    logic [PtrWidth-1:0]      rdPtrQ;
    logic [CountWidth-1:0]    countQ;
    logic [WORD_WIDTH-1:0]    holdInstrQ;
    logic [ADDRESS_WIDTH-1:0] holdPcQ;

    logic                     hasSlot;
    logic                     instrValidW;
    logic                     push;
    logic                     pop;

    // Handshake decode; redirect overrides both push and pop.
    always_comb begin
        hasSlot     = countQ < CountWidth'(DEPTH);
        instrValidW = countQ != '0;
        push        = (stateQ == StWaitDone) && !bus.busy && !discardQ && !bus.redirect;
        pop         = instrValidW && bus.instrReady && !bus.redirect;
    end

    // Fetch FSM: request, wait for busy to rise, capture on its fall.
    // ip mirrors pc while idle; during a transaction pc may hold a redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ        <= StIdle;
            pcQ           <= RESET_PC;
            ipQ           <= RESET_PC;
            startLoadingQ <= 1'b0;
            discardQ      <= 1'b0;
        end else begin
            startLoadingQ <= 1'b0;
            case (stateQ)
                StIdle: begin
                    if (bus.redirect) begin
                        pcQ <= bus.redirectPc;
                        ipQ <= bus.redirectPc;
                    end else if (hasSlot) begin
                        ipQ           <= pcQ;
                        startLoadingQ <= 1'b1;
                        stateQ        <= StReq;
                    end
                end
                StReq: begin
                    stateQ <= StWaitBusy;
                    if (bus.redirect) begin
                        pcQ      <= bus.redirectPc;
                        discardQ <= 1'b1;
                    end
                end
                StWaitBusy: begin
                    if (bus.busy) begin
                        stateQ <= StWaitDone;
                    end
                    if (bus.redirect) begin
                        pcQ      <= bus.redirectPc;
                        discardQ <= 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!bus.busy) begin
                        // Capture edge: the in-flight result is consumed either way.
                        stateQ   <= StIdle;
                        discardQ <= 1'b0;
                        if (bus.redirect) begin
                            pcQ <= bus.redirectPc;
                            ipQ <= bus.redirectPc;
                        end else if (discardQ) begin
                            ipQ <= pcQ;
                        end else begin
                            pcQ <= ipQ + ADDRESS_WIDTH'(4);
                            ipQ <= ipQ + ADDRESS_WIDTH'(4);
                        end
                    end else if (bus.redirect) begin
                        pcQ      <= bus.redirectPc;
                        discardQ <= 1'b1;
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    // Prefetch FIFO; a flush resets pointers only, storage keeps stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memWord    <= '{default: '0};
            memPc      <= '{default: '0};
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            holdInstrQ <= '0;
            holdPcQ    <= '0;
        end else begin
            if (instrValidW) begin
                holdInstrQ <= memWord[rdPtrQ];
                holdPcQ    <= memPc[rdPtrQ];
            end
            if (bus.redirect) begin
                wrPtrQ <= '0;
                rdPtrQ <= '0;
                countQ <= '0;
            end else begin
                if (push) begin
                    memWord[wrPtrQ] <= bus.opcode;
                    memPc[wrPtrQ]   <= ipQ;
                    wrPtrQ          <= wrPtrQ + PtrWidth'(1);
                end
                if (pop) begin
                    rdPtrQ <= rdPtrQ + PtrWidth'(1);
                end
                if (push && !pop) begin
                    countQ <= countQ + CountWidth'(1);
                end else if (pop && !push) begin
                    countQ <= countQ - CountWidth'(1);
                end
            end
        end
    end

    // Outputs: head entry while valid, otherwise the last head shown.
    always_comb begin
        bus.ip           = ipQ;
        bus.startLoading = startLoadingQ;
        bus.instrValid   = instrValidW;
        bus.instr        = instrValidW ? memWord[rdPtrQ] : holdInstrQ;
        bus.instrPc      = instrValidW ? memPc[rdPtrQ] : holdPcQ;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (reset PC 0 and 0xFFFFFFFC),
// each with a small opcode-buffer model holding busy high for LAT cycles.
module tb_fetch_sequencer;
    localparam int LAT = 8;

    logic clk = 1'b0;
    logic reset;
    bit   basicMode;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32)) busA ();
    fetch_sequencer_if #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32)) busB ();

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    // Opcode returned by the buffer model for a given address.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (basicMode && a == 32'h0) return 32'h3C01_0001;
        return 32'h1111_1111 * ({2'b00, a[31:2]} + 32'd1);
    endfunction

    // Buffer model A
    logic        activeA;
    int          cntA;
    logic [31:0] addrA;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busA.busy <= 1'b0; busA.opcode <= '0; activeA <= 1'b0; cntA <= 0; addrA <= '0;
        end else if (!activeA) begin
            if (busA.startLoading) begin
                activeA <= 1'b1; busA.busy <= 1'b1; addrA <= busA.ip; cntA <= LAT - 1;
            end
        end else if (cntA != 0) begin
            cntA <= cntA - 1;
        end else begin
            busA.busy <= 1'b0; busA.opcode <= word(addrA); activeA <= 1'b0;
        end
    end

    // Buffer model B
    logic        activeB;
    int          cntB;
    logic [31:0] addrB;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busB.busy <= 1'b0; busB.opcode <= '0; activeB <= 1'b0; cntB <= 0; addrB <= '0;
        end else if (!activeB) begin
            if (busB.startLoading) begin
                activeB <= 1'b1; busB.busy <= 1'b1; addrB <= busB.ip; cntB <= LAT - 1;
            end
        end else if (cntB != 0) begin
            cntB <= cntB - 1;
        end else begin
            busB.busy <= 1'b0; busB.opcode <= word(addrB); activeB <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return busA.startLoading;
            1:       return busA.instrValid;
            2:       return busA.busy;
            3:       return !busA.busy;
            default: return busB.instrValid;
        endcase
    endfunction

    // Advance negedge by negedge until the selected condition holds (bounded).
    task automatic waitFor(input string tag, input int sel);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cond(sel)) return;
        end
        checks++;
        errors++;
        $error("FAIL %s timeout observed=no-event expected=event", tag);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    int          pulses;
    bit          sawReq;
    bit          bad;
    bit          got;
    logic [31:0] reqIp;

    initial begin
        reset = 1'b0;
        basicMode = 1'b1;
        busA.instrReady = 1'b0; busA.redirect = 1'b0; busA.redirectPc = '0;
        busB.instrReady = 1'b0; busB.redirect = 1'b0; busB.redirectPc = '0;

        // Reset state
        #12;
        chk("rst validA", busA.instrValid, 0);
        chk("rst startA", busA.startLoading, 0);
        chk("rst ipA", busA.ip, 32'h0);
        chk("rst instrA", busA.instr, 32'h0);
        chk("rst instrPcA", busA.instrPc, 32'h0);
        chk("rst ipB", busB.ip, 32'hFFFF_FFFC);
        chk("rst validB", busB.instrValid, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic fetch
        busA.instrReady = 1'b1;
        waitFor("basic req", 0);
        chk("basic ip", busA.ip, 32'h0);
        @(negedge clk);
        chk("basic pulse", busA.startLoading, 0);
        chk("basic ip hold", busA.ip, 32'h0);
        waitFor("basic valid", 1);
        chk("basic instr", busA.instr, 32'h3C01_0001);
        chk("basic instrPc", busA.instrPc, 32'h0);
        waitFor("basic req2", 0);
        chk("basic ip2", busA.ip, 32'h4);

        // Fill / back-pressure
        busA.instrReady = 1'b0;
        basicMode = 1'b0;
        pulseReset();
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busA.startLoading) pulses++;
        end
        chk("fill requests", pulses, 4);
        chk("fill ip", busA.ip, 32'd16);
        chk("fill valid", busA.instrValid, 1);
        chk("fill head", busA.instr, 32'h1111_1111);
        chk("fill headPc", busA.instrPc, 32'h0);
        busA.instrReady = 1'b1;
        sawReq = 1'b0;
        reqIp = '1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (busA.startLoading && !sawReq) begin sawReq = 1'b1; reqIp = busA.ip; end
            chk("drain instr", busA.instr, word(32'(4 * k)));
            chk("drain pc", busA.instrPc, 32'(4 * k));
        end
        @(negedge clk);
        if (busA.startLoading && !sawReq) begin sawReq = 1'b1; reqIp = busA.ip; end
        chk("drain empty", busA.instrValid, 0);
        chk("resume req", sawReq, 1);
        chk("resume ip", reqIp, 32'd16);

        // Simultaneous push/pop with one entry
        busA.instrReady = 1'b0;
        waitFor("pp first", 1);
        chk("pp first instr", busA.instr, word(32'd16));
        waitFor("pp busy", 2);
        waitFor("pp done", 3);
        busA.instrReady = 1'b1;
        @(negedge clk);
        chk("pp valid", busA.instrValid, 1);
        chk("pp instr", busA.instr, word(32'd20));
        chk("pp instrPc", busA.instrPc, 32'd20);
        @(negedge clk);
        chk("pp single", busA.instrValid, 0);

        // Redirect while the fetch of address 8 is in flight
        busA.instrReady = 1'b0;
        pulseReset();
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (busA.startLoading && busA.ip == 32'h8) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $error("FAIL redir req8 timeout observed=no-event expected=event");
        end
        waitFor("redir busy", 2);
        @(negedge clk);
        chk("redir pre valid", busA.instrValid, 1);
        busA.redirect = 1'b1;
        busA.redirectPc = 32'h100;
        @(negedge clk);
        busA.redirect = 1'b0;
        busA.instrReady = 1'b1;
        chk("redir flush", busA.instrValid, 0);
        chk("redir ip hold", busA.ip, 32'h8);
        bad = 1'b0;
        got = 1'b0;
        reqIp = '1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (busA.instrValid && busA.instrPc == 32'h8) bad = 1'b1;
            if (busA.startLoading) begin got = 1'b1; reqIp = busA.ip; end
        end
        chk("redir dropped", bad, 0);
        chk("redir req ip", reqIp, 32'h100);
        waitFor("redir valid", 1);
        chk("redir instrPc", busA.instrPc, 32'h100);
        chk("redir instr", busA.instr, word(32'h100));

        // Wrap-around on instance B (filled since the last reset)
        repeat (60) @(negedge clk);
        chk("wrap validB", busB.instrValid, 1);
        chk("wrap headPc", busB.instrPc, 32'hFFFF_FFFC);
        chk("wrap head", busB.instr, word(32'hFFFF_FFFC));
        chk("wrap ipB", busB.ip, 32'hC);
        busB.instrReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!busB.instrValid) waitFor("wrap valid", 4);
            chk("wrap pc", busB.instrPc, 32'hFFFF_FFFC + 32'(4 * k));
            @(negedge clk);
        end
        busB.instrReady = 1'b0;

        // Async reset in WAIT_BUSY with two entries queued
        busA.instrReady = 1'b0;
        pulseReset();
        waitFor("mid req1", 0);
        waitFor("mid req2", 0);
        waitFor("mid req3", 0);
        @(negedge clk);
        chk("mid pre valid", busA.instrValid, 1);
        chk("mid pre ip", busA.ip, 32'h8);
        #2 reset = 1'b0;
        #1;
        chk("mid valid", busA.instrValid, 0);
        chk("mid start", busA.startLoading, 0);
        chk("mid ip", busA.ip, 32'h0);
        chk("mid instrPc", busA.instrPc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        waitFor("mid restart", 0);
        chk("mid restart ip", busA.ip, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
